// File: rtl/id_stage_ctrl_if.sv
// Handshake bundles around the decode stage: fetch->ID (fs_ds_if) and ID->EX (ds_es_if).
// The master modport is the producing side in both cases.
interface fs_ds_if;
   logic        fs_valid;
   logic [31:0] fs_inst;
   logic [31:0] fs_pc;
   logic        ds_ready;

   modport master (output fs_valid, fs_inst, fs_pc, input ds_ready);
   modport slave  (input fs_valid, fs_inst, fs_pc, output ds_ready);
endinterface

interface ds_es_if;
   logic        ds_to_es_valid;
   logic        es_ready;
   logic [31:0] ds_pc;
   logic [31:0] ds_src_a;
   logic [31:0] ds_src_b;
   logic [31:0] ds_imm;
   logic [15:0] ds_aluop;
   logic        ds_b_is_imm;
   logic [4:0]  ds_dest;
   logic        ds_mem_read;
   logic [4:0]  ds_mem_wen_pick;

   modport master (output ds_to_es_valid, ds_pc, ds_src_a, ds_src_b, ds_imm, ds_aluop,
                   ds_b_is_imm, ds_dest, ds_mem_read, ds_mem_wen_pick,
                   input es_ready);
   modport slave  (input ds_to_es_valid, ds_pc, ds_src_a, ds_src_b, ds_imm, ds_aluop,
                   ds_b_is_imm, ds_dest, ds_mem_read, ds_mem_wen_pick,
                   output es_ready);
endinterface

// File: rtl/id_stage_ctrl.sv
// MIPS instruction-decode stage: pipeline register, one-hot decode, N_FWD-channel bypass
// with pending-producer interlock, and branch/jump resolution in ID.
module id_stage_ctrl #(
   parameter int          N_FWD    = 2,
   parameter bit          BDS      = 1'b1,
   parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
   input  logic                 clk,
   input  logic                 rst,
   fs_ds_if.slave               fs,
   output logic [4:0]           rf_raddr1,
   output logic [4:0]           rf_raddr2,
   input  logic [31:0]          rf_rdata1,
   input  logic [31:0]          rf_rdata2,
   input  logic [N_FWD-1:0]     fwd_valid,
   input  logic [5*N_FWD-1:0]   fwd_dest,
   input  logic [N_FWD-1:0]     fwd_pending,
   input  logic [32*N_FWD-1:0]  fwd_data,
   input  logic                 flush,
   ds_es_if.master              es,
   output logic                 br_taken,
   output logic [31:0]          br_target
);
   typedef enum logic [4:0] {
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_XOR, ALU_NOR, ALU_SLTU,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_A, ALU_B, ALU_NONE = 5'd31
   } alu_e;

   typedef enum logic [3:0] {
      BR_NONE, BR_EQ, BR_NE, BR_GEZ, BR_GTZ, BR_LEZ, BR_LTZ, BR_J, BR_JR
   } br_e;

   typedef struct packed {
      logic [31:0] data;
      logic        pend;
   } byp_t;

   logic        ds_valid_q, ds_valid_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_q, pc_d;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, sa;
   logic [15:0] imm16;
   assign op    = inst_q[31:26];
   assign rs    = inst_q[25:21];
   assign rt    = inst_q[20:16];
   assign rd    = inst_q[15:11];
   assign sa    = inst_q[10:6];
   assign funct = inst_q[5:0];
   assign imm16 = inst_q[15:0];

   // Lowest-index match wins; r0 is hardwired to zero and never waits on a producer.
   function automatic byp_t bypass(input logic [4:0] raddr, input logic [31:0] rf_data,
                                   input logic [N_FWD-1:0] v, input logic [5*N_FWD-1:0] d,
                                   input logic [N_FWD-1:0] p, input logic [32*N_FWD-1:0] x);
      byp_t r;
      r.data = rf_data;
      r.pend = 1'b0;
      for (int i = N_FWD - 1; i >= 0; i--) begin
         if (v[i] && d[5*i +: 5] == raddr) begin
            r.data = x[32*i +: 32];
            r.pend = p[i];
         end
      end
      if (raddr == 5'd0) r = '0;
      return r;
   endfunction

   byp_t byp_a, byp_b;
   assign byp_a = bypass(rs, rf_rdata1, fwd_valid, fwd_dest, fwd_pending, fwd_data);
   assign byp_b = bypass(rt, rf_rdata2, fwd_valid, fwd_dest, fwd_pending, fwd_data);

   alu_e       alu_sel;
   br_e        br_kind;
   logic       use_a, use_b, imm_zext, is_shift, link, b_is_imm, mem_read;
   logic [4:0] dest, wen_pick;

   always_comb begin
      // NOTE: every decode output gets a default first so no path leaves it unassigned (no latches).
      alu_sel  = ALU_NONE;
      br_kind  = BR_NONE;
      use_a    = 1'b0;
      use_b    = 1'b0;
      imm_zext = 1'b0;
      is_shift = 1'b0;
      link     = 1'b0;
      b_is_imm = 1'b0;
      mem_read = 1'b0;
      dest     = 5'd0;
      wen_pick = 5'd0;
      case (op)
         6'h00: begin
            case (funct)
               6'h21: begin alu_sel = ALU_ADD;  dest = rd; use_a = 1'b1; use_b = 1'b1; end
               6'h23: begin alu_sel = ALU_SUB;  dest = rd; use_a = 1'b1; use_b = 1'b1; end
               6'h24: begin alu_sel = ALU_AND;  dest = rd; use_a = 1'b1; use_b = 1'b1; end
               6'h25: begin alu_sel = ALU_OR;   dest = rd; use_a = 1'b1; use_b = 1'b1; end
               6'h26: begin alu_sel = ALU_XOR;  dest = rd; use_a = 1'b1; use_b = 1'b1; end
               6'h27: begin alu_sel = ALU_NOR;  dest = rd; use_a = 1'b1; use_b = 1'b1; end
               6'h2a: begin alu_sel = ALU_SLT;  dest = rd; use_a = 1'b1; use_b = 1'b1; end
               6'h2b: begin alu_sel = ALU_SLTU; dest = rd; use_a = 1'b1; use_b = 1'b1; end
               6'h00: begin alu_sel = ALU_SLL;  dest = rd; use_b = 1'b1; is_shift = 1'b1; end
               6'h02: begin alu_sel = ALU_SRL;  dest = rd; use_b = 1'b1; is_shift = 1'b1; end
               6'h03: begin alu_sel = ALU_SRA;  dest = rd; use_b = 1'b1; is_shift = 1'b1; end
               6'h08: begin br_kind = BR_JR; use_a = 1'b1; end
               6'h09: begin br_kind = BR_JR; use_a = 1'b1; link = 1'b1; dest = rd; end
               default: ;
            endcase
         end
         6'h01: begin
            case (rt)
               5'h00: begin br_kind = BR_LTZ; use_a = 1'b1; end
               5'h01: begin br_kind = BR_GEZ; use_a = 1'b1; end
               5'h10: begin br_kind = BR_LTZ; use_a = 1'b1; link = 1'b1; dest = 5'd31; end
               5'h11: begin br_kind = BR_GEZ; use_a = 1'b1; link = 1'b1; dest = 5'd31; end
               default: ;
            endcase
         end
         6'h02: br_kind = BR_J;
         6'h03: begin br_kind = BR_J; link = 1'b1; dest = 5'd31; end
         6'h04: begin br_kind = BR_EQ;  use_a = 1'b1; use_b = 1'b1; end
         6'h05: begin br_kind = BR_NE;  use_a = 1'b1; use_b = 1'b1; end
         6'h06: begin br_kind = BR_LEZ; use_a = 1'b1; end
         6'h07: begin br_kind = BR_GTZ; use_a = 1'b1; end
         6'h08, 6'h09: begin alu_sel = ALU_ADD;  dest = rt; use_a = 1'b1; b_is_imm = 1'b1; end
         6'h0a: begin alu_sel = ALU_SLT;  dest = rt; use_a = 1'b1; b_is_imm = 1'b1; end
         6'h0b: begin alu_sel = ALU_SLTU; dest = rt; use_a = 1'b1; b_is_imm = 1'b1; end
         6'h0c: begin alu_sel = ALU_AND; dest = rt; use_a = 1'b1; b_is_imm = 1'b1; imm_zext = 1'b1; end
         6'h0d: begin alu_sel = ALU_OR;  dest = rt; use_a = 1'b1; b_is_imm = 1'b1; imm_zext = 1'b1; end
         6'h0e: begin alu_sel = ALU_XOR; dest = rt; use_a = 1'b1; b_is_imm = 1'b1; imm_zext = 1'b1; end
         6'h0f: begin alu_sel = ALU_LUI; dest = rt; b_is_imm = 1'b1; imm_zext = 1'b1; end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
            alu_sel = ALU_ADD; dest = rt; use_a = 1'b1; b_is_imm = 1'b1; mem_read = 1'b1;
         end
         // lwl/lwr merge into the old rt value, so rt is a real source.
         6'h22, 6'h26: begin
            alu_sel = ALU_ADD; dest = rt; use_a = 1'b1; use_b = 1'b1; b_is_imm = 1'b1; mem_read = 1'b1;
         end
         6'h28: begin alu_sel = ALU_ADD; use_a = 1'b1; use_b = 1'b1; b_is_imm = 1'b1; wen_pick = 5'b00100; end
         6'h29: begin alu_sel = ALU_ADD; use_a = 1'b1; use_b = 1'b1; b_is_imm = 1'b1; wen_pick = 5'b00010; end
         6'h2a: begin alu_sel = ALU_ADD; use_a = 1'b1; use_b = 1'b1; b_is_imm = 1'b1; wen_pick = 5'b01000; end
         6'h2b: begin alu_sel = ALU_ADD; use_a = 1'b1; use_b = 1'b1; b_is_imm = 1'b1; wen_pick = 5'b00001; end
         6'h2e: begin alu_sel = ALU_ADD; use_a = 1'b1; use_b = 1'b1; b_is_imm = 1'b1; wen_pick = 5'b10000; end
         default: ;
      endcase
      if (link) begin
         alu_sel  = ALU_B;
         b_is_imm = 1'b1;
      end
   end

   logic [31:0] pc4, imm_ext;
   logic        taken, stall, ds_go, ds_ready;
   assign pc4     = pc_q + 32'd4;
   assign imm_ext = imm_zext ? {16'd0, imm16} : {{16{imm16[15]}}, imm16};

   always_comb begin
      taken = 1'b0;
      case (br_kind)
         BR_EQ:  taken = byp_a.data == byp_b.data;
         BR_NE:  taken = byp_a.data != byp_b.data;
         BR_GEZ: taken = ~byp_a.data[31];
         BR_GTZ: taken = ~byp_a.data[31] && byp_a.data != 32'd0;
         BR_LEZ: taken = byp_a.data[31] || byp_a.data == 32'd0;
         BR_LTZ: taken = byp_a.data[31];
         BR_J, BR_JR: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   assign br_target = (br_kind == BR_J)  ? {pc4[31:28], inst_q[25:0], 2'b00} :
                      (br_kind == BR_JR) ? byp_a.data :
                                           pc4 + {imm_ext[29:0], 2'b00};

   assign stall    = (use_a & byp_a.pend) | (use_b & byp_b.pend);
   assign ds_go    = ds_valid_q & ~stall;
   assign ds_ready = ~ds_valid_q | (ds_go & es.es_ready);
   assign br_taken = ds_go & es.es_ready & ~flush & taken;

   assign fs.ds_ready         = ds_ready;
   assign rf_raddr1           = rs;
   assign rf_raddr2           = rt;
   assign es.ds_to_es_valid   = ds_go & ~flush;
   assign es.ds_pc            = pc_q;
   assign es.ds_src_a         = byp_a.data;
   assign es.ds_src_b         = byp_b.data;
   // Shifts carry their amount in the immediate slot; B stays on rt.
   assign es.ds_imm           = link ? pc_q + 32'd8 : is_shift ? {27'd0, sa} : imm_ext;
   assign es.ds_aluop         = (alu_sel == ALU_NONE) ? 16'd0 : 16'd1 << alu_sel;
   assign es.ds_b_is_imm      = b_is_imm;
   assign es.ds_dest          = dest;
   assign es.ds_mem_read      = mem_read;
   assign es.ds_mem_wen_pick  = wen_pick;

   always_comb begin
      ds_valid_d = ds_valid_q;
      inst_d     = inst_q;
      pc_d       = pc_q;
      if (flush) begin
         ds_valid_d = 1'b0;
      end else if (fs.fs_valid && ds_ready) begin
         inst_d     = fs.fs_inst;
         pc_d       = fs.fs_pc;
         // Without a delay slot, the instruction fetched beside a taken branch is wrong-path.
         ds_valid_d = !(br_taken && !BDS);
      end else if (ds_go && es.es_ready) begin
         ds_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         ds_valid_q <= 1'b0;
         inst_q     <= 32'd0;
         pc_q       <= RESET_PC;
      end else begin
         ds_valid_q <= ds_valid_d;
         inst_q     <= inst_d;
         pc_q       <= pc_d;
      end
   end
endmodule

// File: tb/tb_id_stage_ctrl.sv
// Scoreboard bench for id_stage_ctrl: directed instructions push expected bundles,
// a negedge monitor pops one per ID->EX transfer. A BDS=0 twin checks wrong-path drop.
module tb_id_stage_ctrl;
   localparam logic [31:0] RESET_PC = 32'hbfc00000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fs_ds_if fs();
   ds_es_if es();
   fs_ds_if fs0();
   ds_es_if es0();

   logic [4:0]  rf_raddr1, rf_raddr2, rf0_raddr1, rf0_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2, rf0_rdata1, rf0_rdata2;
   logic [1:0]  fwd_valid, fwd_pending;
   logic [9:0]  fwd_dest;
   logic [63:0] fwd_data;
   logic        flush;
   logic        br_taken, br_taken0;
   logic [31:0] br_target, br_target0;

   // Register file model: rN reads as 0x1000+N.
   assign rf_rdata1  = 32'h1000 + {27'd0, rf_raddr1};
   assign rf_rdata2  = 32'h1000 + {27'd0, rf_raddr2};
   assign rf0_rdata1 = 32'h1000 + {27'd0, rf0_raddr1};
   assign rf0_rdata2 = 32'h1000 + {27'd0, rf0_raddr2};

   assign fs0.fs_valid = fs.fs_valid;
   assign fs0.fs_inst  = fs.fs_inst;
   assign fs0.fs_pc    = fs.fs_pc;
   assign es0.es_ready = es.es_ready;

   id_stage_ctrl #(.N_FWD(2), .BDS(1'b1), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .fs(fs),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_pending(fwd_pending), .fwd_data(fwd_data),
      .flush(flush), .es(es), .br_taken(br_taken), .br_target(br_target)
   );

   id_stage_ctrl #(.N_FWD(2), .BDS(1'b0), .RESET_PC(RESET_PC)) dut_nobds (
      .clk(clk), .rst(rst), .fs(fs0),
      .rf_raddr1(rf0_raddr1), .rf_raddr2(rf0_raddr2), .rf_rdata1(rf0_rdata1), .rf_rdata2(rf0_rdata2),
      .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_pending(fwd_pending), .fwd_data(fwd_data),
      .flush(flush), .es(es0), .br_taken(br_taken0), .br_target(br_target0)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] src_a;
      logic [31:0] src_b;
      logic [31:0] imm;
      logic [15:0] aluop;
      logic        b_is_imm;
      logic [4:0]  dest;
      logic        mem_read;
      logic [4:0]  wen;
      logic        br_taken;
      logic [31:0] br_target;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_bundle(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic [15:0] aluop, input logic bimm,
                                input logic [4:0] dest, input logic mr, input logic [4:0] wen,
                                input logic bt, input logic [31:0] tgt);
      exp_t e;
      e.pc = pc; e.src_a = a; e.src_b = b; e.imm = imm; e.aluop = aluop; e.b_is_imm = bimm;
      e.dest = dest; e.mem_read = mr; e.wen = wen; e.br_taken = bt; e.br_target = tgt;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t act, exp;
      if (!rst && es.ds_to_es_valid && es.es_ready) begin
         act.pc = es.ds_pc; act.src_a = es.ds_src_a; act.src_b = es.ds_src_b; act.imm = es.ds_imm;
         act.aluop = es.ds_aluop; act.b_is_imm = es.ds_b_is_imm; act.dest = es.ds_dest;
         act.mem_read = es.ds_mem_read; act.wen = es.ds_mem_wen_pick; act.br_taken = br_taken;
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_issue: got pc %h, expected no transfer", es.ds_pc);
         end else begin
            exp = sb_q.pop_front();
            act.br_target = exp.br_taken ? br_target : 32'd0;
            check($sformatf("bundle@%h", exp.pc), act, exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
      fs.fs_valid = 1'b1;
      fs.fs_inst  = inst;
      fs.fs_pc    = pc;
      #1 check("ds_ready_on_issue", fs.ds_ready, 1'b1);
      @(posedge clk);
      #1 fs.fs_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      fs.fs_valid = 1'b0; fs.fs_inst = 32'd0; fs.fs_pc = 32'd0;
      es.es_ready = 1'b1;
      fwd_valid = 2'b00; fwd_dest = 10'd0; fwd_pending = 2'b00; fwd_data = 64'd0;
      flush = 1'b0;

      #2;
      check("rst_to_es_valid", es.ds_to_es_valid, 1'b0);
      check("rst_br_taken", br_taken, 1'b0);
      check("rst_dest", es.ds_dest, 5'd0);
      check("rst_mem", {es.ds_mem_read, es.ds_mem_wen_pick}, 6'd0);
      check("rst_pc", es.ds_pc, RESET_PC);
      check("rst_ready", fs.ds_ready, 1'b1);
      tick();
      rst = 1'b0;
      tick();

      // addiu $2,$0,5
      expect_bundle(32'h100, 32'd0, 32'h1002, 32'd5, 16'h0004, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 32'd0);
      issue(32'h24020005, 32'h100);
      tick();

      // addu $3,$2,$2 with two matching channels: ch0 (data 7) wins over ch1 (data 9)
      fwd_valid = 2'b11; fwd_dest = {5'd2, 5'd2}; fwd_data = {32'd9, 32'd7};
      expect_bundle(32'h104, 32'd7, 32'd7, 32'h1821, 16'h0004, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 32'd0);
      issue(32'h00421821, 32'h104);
      tick();
      fwd_valid = 2'b00;

      // Load-use: ch0 pending for 2 cycles; older non-pending ch1 must not bypass it
      fwd_valid = 2'b11; fwd_dest = {5'd2, 5'd2}; fwd_pending = 2'b01; fwd_data = {32'h99, 32'h0};
      expect_bundle(32'h108, 32'h55, 32'd0, 32'h1821, 16'h0004, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 32'd0);
      issue(32'h00401821, 32'h108);
      for (int k = 0; k < 2; k++) begin
         check("stall_no_issue", es.ds_to_es_valid, 1'b0);
         check("stall_not_ready", fs.ds_ready, 1'b0);
         tick();
      end
      fwd_pending = 2'b00; fwd_data = {32'h99, 32'h55};
      tick();
      fwd_valid = 2'b00;

      // Back-to-back: lw $5,8($2); sw $6,-4($1); ori $7,$0,0x8000; undefined opcode
      expect_bundle(32'h10c, 32'h1002, 32'h1005, 32'd8, 16'h0004, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 32'd0);
      expect_bundle(32'h110, 32'h1001, 32'h1006, 32'hfffffffc, 16'h0004, 1'b1, 5'd0, 1'b0, 5'b00001, 1'b0, 32'd0);
      expect_bundle(32'h114, 32'd0, 32'h1007, 32'h8000, 16'h0002, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 32'd0);
      expect_bundle(32'h118, 32'd0, 32'd0, 32'd0, 16'h0000, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
      issue(32'h8c450008, 32'h10c);
      issue(32'hac26fffc, 32'h110);
      issue(32'h34078000, 32'h114);
      issue(32'hfc000000, 32'h118);
      tick();

      // beq $1,$1,+4 at 0x200 with a delay-slot fetch in the branch cycle
      expect_bundle(32'h200, 32'h1001, 32'h1001, 32'd4, 16'h0000, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 32'h214);
      expect_bundle(32'h204, 32'd0, 32'h1004, 32'd9, 16'h0004, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 32'd0);
      issue(32'h10210004, 32'h200);
      fs.fs_valid = 1'b1; fs.fs_inst = 32'h24040009; fs.fs_pc = 32'h204;
      #1;
      check("beq_taken", br_taken, 1'b1);
      check("beq_target", br_target, 32'h214);
      check("beq_taken_nobds", br_taken0, 1'b1);
      check("beq_ds_ready", fs.ds_ready, 1'b1);
      @(posedge clk);
      #1 fs.fs_valid = 1'b0;
      #1;
      check("beq_single_pulse", br_taken, 1'b0);
      check("bds_slot_kept", es.ds_to_es_valid, 1'b1);
      check("nobds_slot_dropped", es0.ds_to_es_valid, 1'b0);
      tick();

      // jal idx=0x40 at 0x80000000, EX back-pressure for 3 cycles
      es.es_ready = 1'b0;
      expect_bundle(32'h80000000, 32'd0, 32'd0, 32'h80000008, 16'h2000, 1'b1, 5'd31, 1'b0, 5'd0, 1'b1, 32'h80000100);
      issue(32'h0c000040, 32'h80000000);
      for (int k = 0; k < 3; k++) begin
         check("jal_hold_no_br", br_taken, 1'b0);
         check("jal_hold_valid", es.ds_to_es_valid, 1'b1);
         check("jal_hold_not_ready", fs.ds_ready, 1'b0);
         check("jal_hold_pc", es.ds_pc, 32'h80000000);
         tick();
      end
      es.es_ready = 1'b1;
      tick();

      // Flush together with a taken branch and a fetch
      issue(32'h10210004, 32'h300);
      flush = 1'b1;
      fs.fs_valid = 1'b1; fs.fs_inst = 32'h24050001; fs.fs_pc = 32'h304;
      #1;
      check("flush_no_br", br_taken, 1'b0);
      check("flush_no_br_nobds", br_taken0, 1'b0);
      check("flush_no_issue", es.ds_to_es_valid, 1'b0);
      @(posedge clk);
      #1 flush = 1'b0; fs.fs_valid = 1'b0;
      #1;
      check("flush_empty_next", es.ds_to_es_valid, 1'b0);
      check("flush_ready_next", fs.ds_ready, 1'b1);
      tick();

      // Reset asserted mid-stall
      fwd_valid = 2'b01; fwd_dest = {5'd0, 5'd2}; fwd_pending = 2'b01;
      issue(32'h00401821, 32'h400);
      check("pre_rst_stalled", fs.ds_ready, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("midrst_valid", es.ds_to_es_valid, 1'b0);
      check("midrst_pc", es.ds_pc, RESET_PC);
      check("midrst_dest", es.ds_dest, 5'd0);
      check("midrst_br", br_taken, 1'b0);
      check("midrst_mem", {es.ds_mem_read, es.ds_mem_wen_pick}, 6'd0);
      check("midrst_ready", fs.ds_ready, 1'b1);
      fwd_valid = 2'b00; fwd_pending = 2'b00;
      tick();
      rst = 1'b0;
      tick();
      tick();

      check("scoreboard_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/id_stage_ctrl.md
Name: id_stage_ctrl

Overview:
- Registered MIPS instruction-decode stage: pipeline register between fetch and execute, with valid/ready handshakes on both sides.
- Decodes the latched instruction into a one-hot control bundle and selects operands through N_FWD parametrised bypass channels.
- Interlocks on pending producers, for example a load still in EX.
- Resolves branches and jumps in ID, with an optional branch-delay-slot mode.

Parameters:
- N_FWD, 2, number of bypass channels; channel 0 is the youngest and has the highest priority.
- BDS, 1, 1 = MIPS delay slot kept; 0 = the wrong-path instruction accepted alongside a taken branch is discarded.
- RESET_PC, 32'hbfc00000, value of ds_pc after reset.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- fs_valid  input  1  fetch has an instruction
- fs_inst  input  32  instruction word
- fs_pc  input  32  instruction PC
- ds_ready  output  1  ID accepts this cycle
- rf_raddr1  output  5  rs field of latched instruction
- rf_raddr2  output  5  rt field of latched instruction
- rf_rdata1  input  32  register file read data, port 1 (combinational)
- rf_rdata2  input  32  register file read data, port 2 (combinational)
- fwd_valid  input  N_FWD  channel holds a live register writer
- fwd_dest  input  5*N_FWD  writer destination; channel i = bits [5i+4:5i]
- fwd_pending  input  N_FWD  writer result not yet available
- fwd_data  input  32*N_FWD  writer result
- flush  input  1  synchronous kill of ID contents
- es_ready  input  1  execute accepts this cycle
- ds_to_es_valid  output  1  bundle valid to EX
- ds_pc  output  32  latched PC
- ds_src_a  output  32  rs operand after bypass
- ds_src_b  output  32  rt operand after bypass
- ds_imm  output  32  sign/zero-extended imm16; pc+8 for link instructions
- ds_aluop  output  16  one-hot ALU operation, bit order and/or/add/sub/slt/xor/nor/sltu/sll/srl/sra/lui/a/b
- ds_b_is_imm  output  1  ALU B takes ds_imm
- ds_dest  output  5  destination register; 0 = no write
- ds_mem_read  output  1  load
- ds_mem_wen_pick  output  5  one-hot store type: sw/sh/sb/swl/swr
- br_taken  output  1  redirect fetch (single-cycle pulse)
- br_target  output  32  redirect address

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: ds_valid=0, inst register=0 (NOP), ds_pc=RESET_PC. All outputs are deasserted: ds_to_es_valid=0, br_taken=0, ds_dest=0, ds_mem_*=0.
- Handshake:
  - ds_go = ds_valid & ~stall.
  - ds_ready = ~ds_valid | (ds_go & es_ready).
  - ds_to_es_valid = ds_go & ~flush.
  - fs_valid & ds_ready latches inst/pc and sets ds_valid=1.
  - Otherwise, ds_go & es_ready clears ds_valid.
  - Outputs hold stable while ds_to_es_valid=1 & es_ready=0.
- Decoded subset:
  - Immediate: addi/addiu/slti/sltiu/andi/ori/xori/lui.
  - Memory: lb/lbu/lh/lhu/lw/lwl/lwr/sb/sh/sw/swl/swr.
  - Branches and jumps: beq/bne/bgez/bgtz/blez/bltz/bgezal/bltzal/j/jal.
  - R-type: addu/subu/and/or/xor/nor/slt/sltu/sll/srl/sra/jr/jalr.
  - Any other encoding decodes as NOP: dest=0, no memory operation, no branch. It still flows through to EX.
- Destination: rt for immediate ops and loads; rd for R-type; 31 for jal/bgezal/bltzal; rd for jalr.
- Link instructions: ds_imm=pc+8, aluop=b, ds_b_is_imm=1.
- Source use: src_a is used by all listed instructions except j/jal/lui/sll/srl/sra; src_b is used by R-type, beq/bne, stores and lwl/lwr.
- Bypass:
  - Channel i matches when fwd_valid[i] & fwd_dest[i]==raddr & raddr!=0.
  - The lowest matching index wins; with no match, rf_rdata is used.
  - raddr==0 always yields 0.
  - stall=1 when a used source's winning channel has fwd_pending=1. An older non-pending match never overrides a younger pending match.
- Branch resolution: uses bypassed operands, with signed comparisons on bit 31 and ==0.
- Branch targets:
  - Conditional branches: pc+4+(sext(imm16)<<2).
  - j/jal: {pc+4[31:28], idx26, 2'b00}.
  - jr/jalr: src_a.
- br_taken: high exactly in the cycle ds_go & es_ready & ~flush & taken. It is never asserted while stalled or flushed, and pulses at most once per instruction.
- BDS=0: an fs instruction latched in the same cycle br_taken=1 is dropped, so ds_valid=0 next cycle. BDS=1: it is kept as the delay slot.
- Flush: has highest priority. ds_valid=0 next cycle, and any simultaneous fs acceptance is discarded. br_taken stays 0.
- Reset mid-stall: everything clears immediately. The stalled instruction is lost.

Test Plan:
- Reset then `addiu $2,$0,5` (0x24020005) at pc 0x100, es_ready=1 → ds_to_es_valid 1 cycle later; dest=2, ds_imm=5, aluop add, ds_b_is_imm=1.
- `addu $3,$2,$2` with fwd ch0 {valid, dest=2, data=7} and ch1 {valid, dest=2, data=9} → src_a=src_b=7.
- Load-use: ch0 {dest=2, pending=1} for 2 cycles under `addu $3,$2,$0` → ds_to_es_valid=0 and ds_ready=0 for 2 cycles. Bundle issues the cycle pending drops.
- `beq $1,$1,+4` at pc 0x200, BDS=1 → single br_taken pulse, br_target=0x214; next fs instruction kept. With BDS=0 the same-cycle fs instruction is dropped.
- `jal` idx=0x40 at 0x80000000 → target 0x80000100, dest=31, ds_imm=0x80000008. es_ready=0 for 3 cycles → no br_taken until accepted.
- Flush asserted together with a taken branch and fs_valid → no br_taken, ds_valid=0 next cycle. rst pulsed mid-stall → all outputs at reset values asynchronously.
